// File: rtl/scanline_irq_counter_if.sv
// CPU-side bus seen by the scanline IRQ stage: the same $8000-$FFFF
// write-decode inputs the bank-register latch uses.
interface scanline_irq_counter_if;
    logic        romsel;       // low = CPU access to $8000-$FFFF
    logic        cpu_rw_in;    // 0 = write
    logic [14:0] cpu_addr_in;  // CPU A14..A0
    logic [7:0]  cpu_data_in;  // CPU data

    modport master (output romsel, cpu_rw_in, cpu_addr_in, cpu_data_in);
    modport slave  (input  romsel, cpu_rw_in, cpu_addr_in, cpu_data_in);
endinterface

// File: rtl/scanline_irq_counter.sv
// MMC3-style scanline IRQ stage. Decodes CPU writes to $C000-$FFFF, counts
// filtered rising edges of PPU A12 and pulls the open-drain irq line low
// once the programmed number of scanlines has passed. All state moves on
// the falling edge of m2, the same edge the bank-register latch uses.
module scanline_irq_counter #(
    parameter int A12_LOW_MIN = 3,    // m2 cycles A12 must be low before a rise counts
    parameter int CNT_W       = 8,    // counter/latch width
    parameter bit OLD_STYLE   = 1'b0  // 1 = IRQ only when a decrement reaches 0
) (
    input  logic                    m2,
    input  logic                    reset,
    input  logic                    mapper_enable,
    scanline_irq_counter_if.slave   cpu,
    input  logic                    ppu_a12,
    output wire                     irq,
    output logic                    irq_pending
);

    localparam int              LOW_W   = $clog2(A12_LOW_MIN + 1);
    localparam logic [LOW_W-1:0] LOW_MAX = LOW_W'(A12_LOW_MIN);

    // Register select = {A14, A13, A0}
    localparam logic [2:0] SEL_LATCH  = 3'b100;  // $C000
    localparam logic [2:0] SEL_RELOAD = 3'b101;  // $C001
    localparam logic [2:0] SEL_IRQ_DIS = 3'b110; // $E000
    localparam logic [2:0] SEL_IRQ_EN  = 3'b111; // $E001

    // A12 filter state
    logic             a12_meta_q, a12_meta_d;
    logic             a12_s_q,    a12_s_d;
    logic             a12_prev_q, a12_prev_d;
    logic [LOW_W-1:0] low_cnt_q,  low_cnt_d;
    logic             clk_evt;

    // Register / counter state
    logic [CNT_W-1:0] latch_q,       latch_d;
    logic [CNT_W-1:0] counter_q,     counter_d;
    logic             reload_q,      reload_d;
    logic             irq_enable_q,  irq_enable_d;
    logic             irq_pending_q, irq_pending_d;

    logic       wr;
    logic [2:0] reg_sel;
    logic       from_dec;
    logic       enable_eff;
    logic       set_irq;

    // A12 synchroniser, low-time qualification and rising-edge event
    always_comb begin
        a12_meta_d = ppu_a12;
        a12_s_d    = a12_meta_q;
        a12_prev_d = a12_s_q;
        if (a12_s_q) begin
            low_cnt_d = '0;
        end else if (low_cnt_q != LOW_MAX) begin
            low_cnt_d = low_cnt_q + LOW_W'(1);
        end else begin
            low_cnt_d = low_cnt_q;
        end
        clk_evt = a12_s_q & ~a12_prev_q & (low_cnt_q == LOW_MAX);
    end

    // CPU register writes, scanline counter and pending-IRQ update
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        latch_d       = latch_q;
        counter_d     = counter_q;
        reload_d      = reload_q;
        irq_enable_d  = irq_enable_q;
        irq_pending_d = irq_pending_q;
        from_dec      = 1'b0;
        set_irq       = 1'b0;

        wr         = mapper_enable & ~cpu.romsel & ~cpu.cpu_rw_in;
        reg_sel    = {cpu.cpu_addr_in[14], cpu.cpu_addr_in[13], cpu.cpu_addr_in[0]};
        // An $E001 write on the clocking edge already enables this edge's zero check
        enable_eff = irq_enable_q | (wr & (reg_sel == SEL_IRQ_EN));

        if (clk_evt) begin
            if (counter_q == '0 || reload_q) begin
                counter_d = latch_q;   // old latch, even if $C000 is written now
                reload_d  = 1'b0;
            end else begin
                counter_d = counter_q - CNT_W'(1);
                from_dec  = 1'b1;
            end
            set_irq = (counter_d == '0) & enable_eff & (~OLD_STYLE | from_dec);
        end

        if (wr) begin
            case (reg_sel)
                SEL_LATCH:   latch_d = CNT_W'(cpu.cpu_data_in);
                SEL_RELOAD: begin
                    counter_d = '0;
                    reload_d  = 1'b1;
                    set_irq   = 1'b0;  // the write wins over a same-edge clock
                end
                SEL_IRQ_DIS: begin
                    irq_enable_d = 1'b0;
                    set_irq      = 1'b0;
                end
                SEL_IRQ_EN:  irq_enable_d = 1'b1;
                default: ;             // $8000-$BFFF belongs to the bank latch
            endcase
        end

        if (set_irq) begin
            irq_pending_d = 1'b1;
        end
        if (wr && reg_sel == SEL_IRQ_DIS) begin
            irq_pending_d = 1'b0;
        end
    end

    // State register on the falling edge of m2 with synchronous reset/disable
    always_ff @(negedge m2) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (reset || !mapper_enable) begin
            a12_meta_q    <= 1'b0;
            a12_s_q       <= 1'b0;
            a12_prev_q    <= 1'b0;
            low_cnt_q     <= '0;
            latch_q       <= '0;
            counter_q     <= '0;
            reload_q      <= 1'b0;
            irq_enable_q  <= 1'b0;
            irq_pending_q <= 1'b0;
        end else begin
            a12_meta_q    <= a12_meta_d;
            a12_s_q       <= a12_s_d;
            a12_prev_q    <= a12_prev_d;
            low_cnt_q     <= low_cnt_d;
            latch_q       <= latch_d;
            counter_q     <= counter_d;
            reload_q      <= reload_d;
            irq_enable_q  <= irq_enable_d;
            irq_pending_q <= irq_pending_d;
        end
    end

    assign irq_pending = irq_pending_q;
    // Open-drain: only ever drive low
    assign irq = irq_pending_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_scanline_irq_counter.sv
// Bench for scanline_irq_counter: one instance of each OLD_STYLE flavour on
// a shared bus, checked every m2 cycle against a scanline-level model.
module tb_scanline_irq_counter;

    logic m2;
    logic reset;
    logic mapper_enable;
    logic ppu_a12;
    wire  irq0_w, irq1_w;
    logic irq_pending0, irq_pending1;

    // Pull-ups stand in for the cartridge irq line: released reads as 1
    pullup (irq0_w);
    pullup (irq1_w);

    scanline_irq_counter_if bus ();

    scanline_irq_counter #(.A12_LOW_MIN(3), .CNT_W(8), .OLD_STYLE(1'b0)) dut0 (
        .m2(m2), .reset(reset), .mapper_enable(mapper_enable), .cpu(bus),
        .ppu_a12(ppu_a12), .irq(irq0_w), .irq_pending(irq_pending0));

    scanline_irq_counter #(.A12_LOW_MIN(3), .CNT_W(8), .OLD_STYLE(1'b1)) dut1 (
        .m2(m2), .reset(reset), .mapper_enable(mapper_enable), .cpu(bus),
        .ppu_a12(ppu_a12), .irq(irq1_w), .irq_pending(irq_pending1));

    initial begin
        m2 = 1'b1;
        forever #5 m2 = ~m2;
    end

    int total = 0;
    int bad   = 0;
    string phase = "init";

    // Driven values for the next m2 falling edge
    bit          rst_v, en_v, romsel_v, rw_v, a12_v;
    logic [14:0] addr_v;
    logic [7:0]  data_v;

    // Model: register file per instance plus the history of the
    // synchronised A12 level (one entry per m2 cycle since reset).
    typedef struct {
        bit [7:0] latch;
        bit [7:0] cnt;
        bit       reload;
        bit       en;
        bit       pend;
    } mstate_t;
    mstate_t m [2];
    bit      lv[$];
    bit      raw_prev;

    task automatic check(input string name, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%0h expected=%0h", phase, name, obs, exp);
        end
    endtask

    // One falling edge of the model with the inputs currently driven
    task automatic model_edge();
        bit       ev, wr;
        bit [2:0] sel;
        if (rst_v || !en_v) begin
            for (int i = 0; i < 2; i++) m[i] = '{default: 0};
            lv.delete();
            lv.push_back(1'b0);
            raw_prev = 1'b0;
            return;
        end
        // A rise counts when the synced level went high after >= 3 low cycles
        ev = (lv.size() >= 4) && lv[lv.size()-1] && !lv[lv.size()-2]
             && !lv[lv.size()-3] && !lv[lv.size()-4];
        lv.push_back(raw_prev);   // two-flop delay of the raw pin
        raw_prev = a12_v;
        if (lv.size() > 8) lv.delete(0);

        wr  = !romsel_v && !rw_v;
        sel = {addr_v[14], addr_v[13], addr_v[0]};
        for (int i = 0; i < 2; i++) begin
            mstate_t  s;
            bit       fire, dec;
            bit [7:0] nxt;
            s = m[i]; fire = 1'b0; dec = 1'b0; nxt = s.cnt;
            if (ev) begin
                if (s.cnt == 8'd0 || s.reload) begin
                    nxt      = s.latch;
                    s.reload = 1'b0;
                end else begin
                    nxt = s.cnt - 8'd1;
                    dec = 1'b1;
                end
                fire = (nxt == 8'd0) && (s.en || (wr && sel == 3'b111)) && (i == 0 || dec);
            end
            s.cnt = nxt;
            if (wr) begin
                case (sel)
                    3'b100: s.latch = data_v;
                    3'b101: begin s.cnt = 8'd0; s.reload = 1'b1; fire = 1'b0; end
                    3'b110: begin s.en = 1'b0; fire = 1'b0; end
                    3'b111: s.en = 1'b1;
                    default: ;
                endcase
            end
            if (fire) s.pend = 1'b1;
            if (wr && sel == 3'b110) s.pend = 1'b0;
            m[i] = s;
        end
    endtask

    task automatic tick();
        reset           = rst_v;
        mapper_enable   = en_v;
        bus.romsel      = romsel_v;
        bus.cpu_rw_in   = rw_v;
        bus.cpu_addr_in = addr_v;
        bus.cpu_data_in = data_v;
        ppu_a12         = a12_v;
        @(negedge m2);
        model_edge();
        @(posedge m2);
        check("pend0", irq_pending0, m[0].pend);
        check("pend1", irq_pending1, m[1].pend);
        check("irq0",  irq0_w, m[0].pend ? 1'b0 : 1'b1);
        check("irq1",  irq1_w, m[1].pend ? 1'b0 : 1'b1);
        check("cnt0",  dut0.counter_q, m[0].cnt);
        check("cnt1",  dut1.counter_q, m[1].cnt);
    endtask

    task automatic cpu_wr(input logic [14:0] addr, input logic [7:0] data);
        romsel_v = 1'b0; rw_v = 1'b0; addr_v = addr; data_v = data;
        tick();
        romsel_v = 1'b1; rw_v = 1'b1;
    endtask

    task automatic hold(input bit lvl, input int n);
        a12_v = lvl;
        repeat (n) tick();
    endtask

    task automatic pulse();
        hold(1'b0, 4);
        hold(1'b1, 2);
    endtask

    initial begin
        rst_v = 1'b1; en_v = 1'b1; romsel_v = 1'b1; rw_v = 1'b1;
        addr_v = '0; data_v = '0; a12_v = 1'b0; raw_prev = 1'b0;
        lv.push_back(1'b0);

        phase = "reset";
        repeat (2) tick();
        rst_v = 1'b0;

        phase = "count";
        cpu_wr(15'h4000, 8'd3);
        cpu_wr(15'h4001, 8'd0);
        cpu_wr(15'h6001, 8'd0);
        repeat (5) pulse();
        hold(1'b0, 4);
        check("t1_pend0", irq_pending0, 1'b1);
        check("t1_cnt0", dut0.counter_q, 8'd3);

        phase = "filter";
        hold(1'b1, 3);            // qualified rise: 3 -> 2
        hold(1'b0, 2);
        hold(1'b1, 3);            // only 2 low cycles: ignored
        hold(1'b0, 3);
        hold(1'b1, 3);            // 3 low cycles: 2 -> 1
        hold(1'b0, 4);
        check("t2_cnt0", dut0.counter_q, 8'd1);

        phase = "ack";
        cpu_wr(15'h6000, 8'd0);
        check("t3_clr", irq_pending0, 1'b0);
        cpu_wr(15'h6001, 8'd0);
        hold(1'b0, 3);
        check("t3_still", irq_pending0, 1'b0);
        pulse();
        hold(1'b0, 4);
        check("t3_refire", irq_pending0, 1'b1);

        phase = "latch0";
        cpu_wr(15'h6000, 8'd0);
        cpu_wr(15'h4000, 8'd0);
        cpu_wr(15'h4001, 8'd0);
        cpu_wr(15'h6001, 8'd0);
        repeat (3) pulse();
        hold(1'b0, 4);
        check("t4_new", irq_pending0, 1'b1);
        check("t4_old", irq_pending1, 1'b0);

        phase = "collide";
        cpu_wr(15'h6000, 8'd0);
        cpu_wr(15'h4000, 8'd4);
        cpu_wr(15'h4001, 8'd0);
        cpu_wr(15'h6001, 8'd0);
        repeat (4) pulse();       // 4, 3, 2, 1
        hold(1'b0, 4);
        hold(1'b1, 2);
        cpu_wr(15'h4001, 8'd0);   // lands on the edge that would reach 0
        check("t5_cnt", dut0.counter_q, 8'd0);
        check("t5_pend", irq_pending0, 1'b0);
        pulse();
        hold(1'b0, 4);
        check("t5_reload", dut0.counter_q, 8'd4);

        phase = "disable";
        cpu_wr(15'h4000, 8'd1);
        cpu_wr(15'h4001, 8'd0);
        pulse();
        pulse();
        cpu_wr(15'h4000, 8'd5);
        pulse();
        hold(1'b0, 4);
        check("t6_cnt5", dut0.counter_q, 8'd5);
        check("t6_pend", irq_pending0, 1'b1);
        en_v = 1'b0;
        cpu_wr(15'h4000, 8'd7);
        cpu_wr(15'h4000, 8'd9);
        check("t6_latch", dut0.latch_q, 8'd0);
        en_v = 1'b1;

        phase = "midreset";
        cpu_wr(15'h4000, 8'd5);
        cpu_wr(15'h4001, 8'd0);
        cpu_wr(15'h6001, 8'd0);
        pulse();
        hold(1'b0, 4);
        a12_v = 1'b1;
        rst_v = 1'b1;
        tick();
        rst_v = 1'b0;
        cpu_wr(15'h4000, 8'd6);
        hold(1'b1, 3);            // high straight after reset: not a qualified rise
        check("t7_cnt", dut0.counter_q, 8'd0);

        phase = "random";
        for (int n = 0; n < 2000; n++) begin
            rst_v    = ($urandom_range(0, 63) == 0);
            en_v     = ($urandom_range(0, 31) != 0);
            romsel_v = ($urandom_range(0, 1) == 0);
            rw_v     = ($urandom_range(0, 4) < 2);
            addr_v   = 15'($urandom);
            if ($urandom_range(0, 3) != 0) addr_v[14] = 1'b1;
            data_v   = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 2) == 0) a12_v = ~a12_v;
            tick();
        end
        rst_v = 1'b0; en_v = 1'b1; romsel_v = 1'b1; rw_v = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
